// File: rtl/bf_dram_arbiter.sv
// Single-port data-RAM arbiter for the Brainfuck CPU: shares one synchronous DRAM
// between core read, core write-back and host/debug ports with starvation protection.
module bf_dram_arbiter #(
  parameter int unsigned A_WIDTH      = 12,
  parameter int unsigned D_WIDTH      = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               r_req,
  input  logic [A_WIDTH-1:0] r_addr,
  output logic               r_gnt,
  output logic               r_valid,
  output logic [D_WIDTH-1:0] r_data,
  input  logic               w_req,
  input  logic [A_WIDTH-1:0] w_addr,
  input  logic [D_WIDTH-1:0] w_data,
  output logic               w_gnt,
  input  logic               h_req,
  input  logic               h_we,
  input  logic [A_WIDTH-1:0] h_addr,
  input  logic [D_WIDTH-1:0] h_wdata,
  input  logic               h_lock,
  output logic               h_gnt,
  output logic               h_valid,
  output logic [D_WIDTH-1:0] h_rdata,
  output logic               m_ce,
  output logic               m_we,
  output logic [A_WIDTH-1:0] m_a,
  output logic [D_WIDTH-1:0] m_d,
  input  logic [D_WIDTH-1:0] m_q
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_R    = 2'd1,
    TAG_H    = 2'd2
  } tag_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  tag_t       tag_q, tag_d;
  logic [3:0] starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q    <= TAG_NONE;
      starve_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  // A saturated starvation counter lifts the host above both core ports for one cycle.
  always_comb begin
    r_gnt = 1'b0;
    w_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!reset) begin
      if (h_lock)                           h_gnt = h_req;
      else if (h_req && starve_q == LIMIT)  h_gnt = 1'b1;
      else if (w_req)                       w_gnt = 1'b1;
      else if (r_req)                       r_gnt = 1'b1;
      else                                  h_gnt = h_req;
    end
  end

  always_comb begin
    m_ce = 1'b0;
    m_we = 1'b0;
    m_a  = '0;
    m_d  = '0;
    if (w_gnt) begin
      m_ce = 1'b1;
      m_we = 1'b1;
      m_a  = w_addr;
      m_d  = w_data;
    end else if (r_gnt) begin
      m_ce = 1'b1;
      m_a  = r_addr;
    end else if (h_gnt) begin
      m_ce = 1'b1;
      m_we = h_we;
      m_a  = h_addr;
      m_d  = h_we ? h_wdata : '0;
    end
  end

  always_comb begin
    starve_d = '0;
    if (!h_lock && h_req && !h_gnt)
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;

    tag_d = TAG_NONE;
    if (r_gnt)                tag_d = TAG_R;
    else if (h_gnt && !h_we)  tag_d = TAG_H;
  end

  // Response gated by reset so a read granted just before reset is dropped.
  always_comb begin
    r_valid = !reset && (tag_q == TAG_R);
    h_valid = !reset && (tag_q == TAG_H);
    r_data  = r_valid ? m_q : '0;
    h_rdata = h_valid ? m_q : '0;
  end

endmodule

// File: tb/tb_bf_dram_arbiter.sv
// Directed bench for bf_dram_arbiter with a behavioural synchronous single-port DRAM.
module tb_bf_dram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_req, w_req, h_req, h_we, h_lock;
  logic [11:0] r_addr, w_addr, h_addr;
  logic [7:0]  w_data, h_wdata;
  logic        r_gnt, w_gnt, h_gnt, r_valid, h_valid, m_ce, m_we;
  logic [7:0]  r_data, h_rdata, m_d, m_q;
  logic [11:0] m_a;

  logic [7:0]  mem [0:4095];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we) mem[m_a] <= m_d;
      else      m_q <= mem[m_a];
    end
  end

  bf_dram_arbiter #(.A_WIDTH(12), .D_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_valid(r_valid), .r_data(r_data),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_valid(h_valid), .h_rdata(h_rdata),
    .m_ce(m_ce), .m_we(m_we), .m_a(m_a), .m_d(m_d), .m_q(m_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    r_req = 0; w_req = 0; h_req = 0; h_we = 0; h_lock = 0;
  endtask

  initial begin
    m_q = '0;
    mem[12'h005] = 8'h3C;
    mem[12'h020] = 8'h77;

    // Reset with every input high
    reset = 1; r_req = 1; w_req = 1; h_req = 1; h_we = 1; h_lock = 1;
    r_addr = '1; w_addr = '1; h_addr = '1; w_data = '1; h_wdata = '1;
    step; #1;
    chk("rst_gnt",   {r_gnt, w_gnt, h_gnt}, 3'b000);
    chk("rst_valid", {r_valid, h_valid}, 2'b00);
    chk("rst_mem",   {m_ce, m_we}, 2'b00);
    chk("rst_am",    {m_a, m_d}, 20'h0);
    chk("rst_data",  {r_data, h_rdata}, 16'h0);
    step;
    reset = 0; idle; #1;
    chk("idle_ce", m_ce, 1'b0);
    step; #1;
    chk("idle_ce2", {m_ce, r_valid, h_valid}, 3'b000);

    // Single read
    step;
    r_req = 1; r_addr = 12'h005; #1;
    chk("rd_gnt",  {r_gnt, m_ce, m_we}, 3'b110);
    chk("rd_addr", m_a, 12'h005);
    step;
    r_req = 0; #1;
    chk("rd_valid", r_valid, 1'b1);
    chk("rd_data",  r_data, 8'h3C);
    step; #1;
    chk("rd_done", {r_valid, r_data}, 9'h0);

    // RAW collision
    w_req = 1; w_addr = 12'h010; w_data = 8'hA5; r_req = 1; r_addr = 12'h010; #1;
    chk("raw_w", {w_gnt, r_gnt, m_we}, 3'b101);
    step;
    w_req = 0; #1;
    chk("raw_r", {w_gnt, r_gnt}, 2'b01);
    step;
    r_req = 0; #1;
    chk("raw_valid", r_valid, 1'b1);
    chk("raw_data",  r_data, 8'hA5);
    step;

    // Starvation: host read against continuous W and R
    w_req = 1; w_addr = 12'h030; w_data = 8'h11; r_req = 1; r_addr = 12'h031;
    h_req = 1; h_we = 0; h_addr = 12'h020;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("starve_deny%0d", i), {w_gnt, r_gnt, h_gnt}, 3'b100);
      step;
    end
    #1;
    chk("starve_grant", {w_gnt, r_gnt, h_gnt}, 3'b001);
    chk("starve_m", {m_ce, m_we, m_a}, {2'b10, 12'h020});
    step;
    h_req = 0; #1;
    chk("starve_hvalid", {h_valid, h_rdata}, 9'h177);
    chk("starve_wnext", w_gnt, 1'b1);
    step;
    idle;

    // Lock: host writes 0..15 with core requests held high
    h_lock = 1; r_req = 1; w_req = 1; w_addr = 12'h040; w_data = 8'hEE; r_addr = 12'h041;
    for (int i = 0; i < 16; i++) begin
      h_req = 1; h_we = 1; h_addr = 12'(i); h_wdata = 8'(i); #1;
      chk($sformatf("lock_wr%0d", i), {r_gnt, w_gnt, h_gnt, m_we}, 4'b0011);
      step;
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        h_req = 1; h_we = 0; h_addr = 12'(i);
      end else begin
        h_req = 0;
      end
      #1;
      if (i > 0) chk($sformatf("lock_rd%0d", i - 1), {h_valid, h_rdata}, {1'b1, 8'(i - 1)});
      if (i < 16) chk($sformatf("lock_rgnt%0d", i), {r_gnt, w_gnt, h_gnt}, 3'b001);
      step;
    end
    h_lock = 0; #1;
    chk("unlock_w", {w_gnt, m_we, m_a}, {2'b11, 12'h040});
    step;
    idle;

    // Reset mid-read with a partially built starvation count
    h_req = 1; h_we = 0; h_addr = 12'h020; w_req = 1; w_addr = 12'h050;
    step; step;
    w_req = 0; r_req = 1; r_addr = 12'h005; #1;
    chk("mr_rgnt", {r_gnt, h_gnt}, 2'b10);
    step;
    r_req = 0; w_req = 1; reset = 1; #1;
    chk("mr_rst", {r_valid, r_data, w_gnt, h_gnt}, 11'h0);
    step;
    reset = 0; #1;
    chk("mr_after", r_valid, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mr_cnt_deny%0d", i), {w_gnt, h_gnt}, 2'b10);
      step;
    end
    #1;
    chk("mr_cnt_grant", {w_gnt, h_gnt}, 2'b01);
    step;
    idle;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
